f_issue_ctrl: RTL

//  Issue/collect stage wrapped around the f arithmetic kernel (result = (a+b)^2 mod 2^W).

---
 rtl/f_pkg.sv | 15 +
 rtl/f_issue_ctrl_if.sv | 27 ++
 rtl/f_op_fifo.sv | 42 ++++
 rtl/f_issue_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/f_pkg.sv
// Shared types and defaults for the f kernel issue/collect slice.
package f_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_LOW,
      WAIT_HIGH
   } state_t;

   localparam int unsigned F_W    = 32;
   // Wide enough for any TIMEOUT up to 255.
   localparam int unsigned TCNT_W = 8;

endpackage

// File: rtl/f_issue_ctrl_if.sv
// Operand stream, result stream and kernel-side signals of f_issue_ctrl.
interface f_issue_ctrl_if #(
   parameter int unsigned W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         k_start;
   logic [W-1:0] k_a;
   logic [W-1:0] k_b;
   logic [W-1:0] k_result;
   logic         k_done;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;

   modport master (
      output in_valid, in_a, in_b, out_ready, k_result, k_done,
      input  in_ready, k_start, k_a, k_b, out_valid, out_result
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready, k_result, k_done,
      output in_ready, k_start, k_a, k_b, out_valid, out_result
   );
endinterface

// File: rtl/f_op_fifo.sv
// Operand-pair buffer: DEPTH entries of DW bits, pointers wrap mod DEPTH.
module f_op_fifo #(
   parameter int unsigned DW    = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DW-1:0]          din,
   output logic [DW-1:0]          dout,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/f_issue_ctrl.sv
// Issue/collect stage around the f kernel: buffers operand pairs, starts the
// kernel one op at a time and returns results in arrival order.
module f_issue_ctrl
   import f_pkg::*;
#(
   parameter int unsigned W       = F_W,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   f_issue_ctrl_if.slave          bus,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_t              state;
   logic [TCNT_W-1:0]   tcnt;
   logic                k_start;
   logic [W-1:0]        k_a;
   logic [W-1:0]        k_b;
   logic                out_valid;
   logic [W-1:0]        out_result;
   logic [2*W-1:0]      head;
   logic                push;
   logic                pop;

   assign bus.in_ready   = (count < CW'(DEPTH));
   assign push           = bus.in_valid && bus.in_ready;
   assign pop            = (state == ISSUE);
   assign bus.k_start    = k_start;
   assign bus.k_a        = k_a;
   assign bus.k_b        = k_b;
   assign bus.out_valid  = out_valid;
   assign bus.out_result = out_result;

   f_op_fifo #(
      .DW    (2 * W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({bus.in_a, bus.in_b}),
      .dout  (head),
      .count (count)
   );

   // Operands load together with k_start on entry to ISSUE; the head stays
   // valid through ISSUE because the pop only takes effect at its end.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         tcnt       <= '0;
         k_start    <= 1'b0;
         k_a        <= '0;
         k_b        <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         err        <= 1'b0;
      end else begin
         k_start <= 1'b0;
         if (out_valid && bus.out_ready) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (count != '0 && bus.k_done && !out_valid) begin
                  state      <= ISSUE;
                  k_start    <= 1'b1;
                  {k_a, k_b} <= head;
               end
            end
            ISSUE: begin
               state <= WAIT_LOW;
               tcnt  <= '0;
            end
            WAIT_LOW: begin
               if (!bus.k_done) begin
                  state <= WAIT_HIGH;
                  tcnt  <= '0;
               end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (bus.k_done) begin
                  out_result <= bus.k_result;
                  out_valid  <= 1'b1;
                  state      <= IDLE;
               end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
